stmn_frame_aligner: RTL and testbench
=====================================

Name: stmn_frame_aligner

Overview:
- Byte-serial SDH frame aligner for STM-N, with N as a parameter (1, 4, 16). Row geometry is fixed at 9 rows × 270·N columns.
- Sits directly after the line deserializer. Hunts for the A1/A2 framing pattern, confirms frame alignment over several frames, and tags every byte with its row and column.
- Downstream STM/VC4/C4 demapping blocks consume its tagged output.
- Replaces the fixed STM-1-only framing constants with N-scaled geometry and adds a hunt/presync/sync state machine with loss-of-frame hysteresis.

Parameters:
- N, 1, STM order; legal values are 1, 4, 16. Line length = 270·N bytes, A1 run = 3N bytes, A2 run = 3N bytes.
- ROWS, 9, rows per frame.
- A1_BYTE, 8'hF6, framing byte A1.
- A2_BYTE, 8'h28, framing byte A2.
- SYNC_FRAMES, 2, consecutive good framing checks required in PRESYNC before entering SYNC (range 1–7).
- LOSS_FRAMES, 4, consecutive bad framing checks in SYNC that declare loss of frame (range 1–7).
- COL_W, $clog2(270*N), width of the column index.

Ports:
- clk  in  1  line byte clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  8  received byte.
- din_valid  in  1  din qualifier; all counters and checks advance only when this is high.
- dout  out  8  din delayed by one clock.
- dout_valid  out  1  din_valid delayed by one clock.
- row  out  4  row index of dout (0..8); 0 unless state is PRESYNC or SYNC.
- col  out  COL_W  column index of dout (0..270N-1); 0 unless state is PRESYNC or SYNC.
- frame_start  out  1  one-cycle pulse with dout_valid when row=0, col=0 and state is PRESYNC or SYNC.
- in_sync  out  1  high while state is SYNC.
- lof  out  1  one-cycle pulse on the SYNC→HUNT transition.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0, state goes to HUNT, all counters clear.
  - Reset asserted mid-frame discards alignment. Reacquisition restarts from HUNT.
- Latency: one clock from din to dout. row, col and frame_start are registered and aligned to dout.
- States: HUNT, PRESYNC, SYNC (2-bit encoding).
- HUNT, hunt counter hc in 0..6N, evaluated per valid byte:
  - While hc<3N: A1 gives hc+1; any other byte gives hc=0.
  - While hc≥3N:
    - A2 gives hc+1.
    - A1 with hc==3N holds hc (a longer A1 run is allowed).
    - A1 with hc>3N gives hc=1.
    - Any other byte gives hc=0.
  - When hc reaches 6N on the last A2, go to PRESYNC and clear good_cnt. That byte is row 0, col 6N-1, so the next valid byte is tagged row 0, col 6N.
- Position counters (PRESYNC and SYNC):
  - col increments per valid byte and wraps 270N-1→0 with row+1.
  - row wraps 8→0.
- Framing check (PRESYNC and SYNC):
  - Applies to row 0, cols 0..6N-1.
  - Expected byte is A1 for col<3N and A2 otherwise. Any mismatch sets a sticky error flag.
  - The check verdict is taken at row 0, col 6N-1; the flag then clears.
- PRESYNC verdicts:
  - Good: good_cnt+1. When good_cnt reaches SYNC_FRAMES, go to SYNC.
  - Bad: go to HUNT immediately, with hc restarting at 0 on the next byte.
- SYNC verdicts:
  - Good: bad_cnt=0.
  - Bad: bad_cnt+1. When bad_cnt reaches LOSS_FRAMES, go to HUNT and pulse lof.
  - Position counters keep running while bad_cnt<LOSS_FRAMES (flywheel).
- din_valid low: no counter, state or check changes. dout holds its value and dout_valid=0.
- frame_start never fires in HUNT, including for the first frame found. The first pulse is at the following frame's row 0, col 0.
- Frame length is 9·270·N bytes: 2430 for N=1, 9720 for N=4.

Test Plan:
- N=1, reset, then random bytes containing no F6F6F6_282828 sequence for 5000 bytes → stays in HUNT; in_sync=0, frame_start=0, row=col=0.
- N=1, continuous valid frames of 2430 bytes with correct A1/A2 → PRESYNC after the first A2 run. First frame_start at the second frame's first A1 byte plus 1 clk. in_sync rises at the third frame's col 5 verdict (+1 clk). row/col match a reference model on every byte.
- N=1, in SYNC, corrupt one A2 byte in 3 consecutive frames, then a good frame → in_sync stays 1, bad_cnt returns to 0, no lof. Then corrupt 4 consecutive frames → lof pulses once, in_sync=0, state HUNT.
- N=1, extra A1 run (five F6 bytes) then 282828 → acquisition succeeds. Sequence F6F6F6 28 F6 2828 → no acquisition.
- N=4, din_valid toggling randomly at 50% → frame period 9720 valid bytes. Sync is reached; col reaches exactly 1079 before wrapping to 0.
- Assert rst_n low for 1 clk mid-frame in SYNC → outputs 0 asynchronously. After reset, realign within about 2 frames and reach in_sync after SYNC_FRAMES checks.

Source files
------------

// File: rtl/stmn_frame_aligner.sv
// Byte-serial STM-N frame aligner: hunts for the A1/A2 framing run, confirms alignment over
// several frames and tags every byte with its row/column position, one clock after input.
module stmn_frame_aligner #(
    parameter int unsigned N           = 1,
    parameter int unsigned ROWS        = 9,
    parameter logic [7:0]  A1_BYTE     = 8'hF6,
    parameter logic [7:0]  A2_BYTE     = 8'h28,
    parameter int unsigned SYNC_FRAMES = 2,
    parameter int unsigned LOSS_FRAMES = 4,
    parameter int unsigned COL_W       = $clog2(270 * N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic [7:0]       dout,
    output logic             dout_valid,
    output logic [3:0]       row,
    output logic [COL_W-1:0] col,
    output logic             frame_start,
    output logic             in_sync,
    output logic             lof
);

    localparam int unsigned HcW = $clog2(6 * N + 1);

    localparam logic [HcW-1:0]   HcOne      = HcW'(1);
    localparam logic [HcW-1:0]   HcA1End    = HcW'(3 * N);
    localparam logic [HcW-1:0]   HcDone     = HcW'(6 * N);
    localparam logic [COL_W-1:0] ColOne     = COL_W'(1);
    localparam logic [COL_W-1:0] ColA2First = COL_W'(3 * N);
    localparam logic [COL_W-1:0] ColChkLast = COL_W'(6 * N - 1);
    localparam logic [COL_W-1:0] ColResume  = COL_W'(6 * N);
    localparam logic [COL_W-1:0] ColLast    = COL_W'(270 * N - 1);
    localparam logic [3:0]       RowOne     = 4'd1;
    localparam logic [3:0]       RowLast    = 4'(ROWS - 1);
    localparam logic [2:0]       CntOne     = 3'd1;
    localparam logic [2:0]       SyncTarget = 3'(SYNC_FRAMES);
    localparam logic [2:0]       LossTarget = 3'(LOSS_FRAMES);

    localparam logic [1:0] StHunt    = 2'd0;
    localparam logic [1:0] StPresync = 2'd1;
    localparam logic [1:0] StSync    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [HcW-1:0]   hc_q, hc_d;
    logic [3:0]       pos_row_q, pos_row_d;
    logic [COL_W-1:0] pos_col_q, pos_col_d;
    logic             err_q, err_d;
    logic [2:0]       good_q, good_d;
    logic [2:0]       bad_q, bad_d;
    logic             lof_d;

    logic [7:0]       dout_q;
    logic             dout_valid_q;
    logic [3:0]       row_q;
    logic [COL_W-1:0] col_q;
    logic             frame_start_q;
    logic             lof_q;

    logic [HcW-1:0]   hunt_next;
    logic [3:0]       pos_row_nxt;
    logic [COL_W-1:0] pos_col_nxt;
    logic             aligned;
    logic             in_chk;
    logic [7:0]       exp_byte;
    logic             mismatch;
    logic             verdict;
    logic             frame_ok;
    logic [2:0]       good_inc;
    logic [2:0]       bad_inc;

    assign aligned  = (state_q == StPresync) || (state_q == StSync);
    assign in_chk   = aligned && (pos_row_q == '0) && (pos_col_q <= ColChkLast);
    assign exp_byte = (pos_col_q < ColA2First) ? A1_BYTE : A2_BYTE;
    assign mismatch = in_chk && (din != exp_byte);
    assign verdict  = aligned && (pos_row_q == '0) && (pos_col_q == ColChkLast);
    assign frame_ok = !err_q && !mismatch;
    assign good_inc = good_q + CntOne;
    assign bad_inc  = bad_q + CntOne;

    // Hunt counter: A1 run of at least 3N followed by exactly 3N A2 bytes.
    always_comb begin
        hunt_next = '0;
        if (hc_q < HcA1End) begin
            if (din == A1_BYTE) begin
                hunt_next = hc_q + HcOne;
            end
        end else if (din == A2_BYTE) begin
            hunt_next = hc_q + HcOne;
        end else if (din == A1_BYTE) begin
            hunt_next = (hc_q == HcA1End) ? hc_q : HcOne;
        end
    end

    always_comb begin
        pos_col_nxt = pos_col_q + ColOne;
        pos_row_nxt = pos_row_q;
        if (pos_col_q == ColLast) begin
            pos_col_nxt = '0;
            pos_row_nxt = (pos_row_q == RowLast) ? '0 : pos_row_q + RowOne;
        end
    end

    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        pos_row_d = pos_row_q;
        pos_col_d = pos_col_q;
        err_d     = err_q;
        good_d    = good_q;
        bad_d     = bad_q;
        lof_d     = 1'b0;
        if (din_valid) begin
            case (state_q)
                StHunt: begin
                    if (hunt_next == HcDone) begin
                        // The last A2 sits at row 0, col 6N-1; resume counting just after it.
                        state_d   = StPresync;
                        hc_d      = '0;
                        pos_row_d = '0;
                        pos_col_d = ColResume;
                        err_d     = 1'b0;
                        good_d    = '0;
                        bad_d     = '0;
                    end else begin
                        hc_d = hunt_next;
                    end
                end
                StPresync, StSync: begin
                    pos_row_d = pos_row_nxt;
                    pos_col_d = pos_col_nxt;
                    err_d     = err_q | mismatch;
                    if (verdict) begin
                        err_d = 1'b0;
                        if (state_q == StPresync) begin
                            if (frame_ok) begin
                                good_d = good_inc;
                                if (good_inc == SyncTarget) begin
                                    state_d = StSync;
                                    bad_d   = '0;
                                end
                            end else begin
                                state_d   = StHunt;
                                hc_d      = '0;
                                pos_row_d = '0;
                                pos_col_d = '0;
                            end
                        end else if (frame_ok) begin
                            bad_d = '0;
                        end else begin
                            bad_d = bad_inc;
                            if (bad_inc == LossTarget) begin
                                state_d   = StHunt;
                                hc_d      = '0;
                                pos_row_d = '0;
                                pos_col_d = '0;
                                bad_d     = '0;
                                lof_d     = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StHunt;
                    hc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StHunt;
            hc_q      <= '0;
            pos_row_q <= '0;
            pos_col_q <= '0;
            err_q     <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            pos_row_q <= pos_row_d;
            pos_col_q <= pos_col_d;
            err_q     <= err_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    // Tags reflect the state the byte was received in, so the byte completing the hunt is
    // still reported as unaligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            frame_start_q <= 1'b0;
            lof_q         <= 1'b0;
        end else begin
            dout_valid_q  <= din_valid;
            lof_q         <= lof_d;
            frame_start_q <= din_valid && aligned && (pos_row_q == '0) && (pos_col_q == '0);
            if (din_valid) begin
                dout_q <= din;
                row_q  <= aligned ? pos_row_q : '0;
                col_q  <= aligned ? pos_col_q : '0;
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign row         = row_q;
    assign col         = col_q;
    assign frame_start = frame_start_q;
    assign in_sync     = (state_q == StSync);
    assign lof         = lof_q;

endmodule

// File: tb/tb_stmn_frame_aligner.sv
// Directed bench for stmn_frame_aligner: an STM-1 instance for hunt, sync, loss and reset
// sequences, and an STM-4 instance fed with gapped valid for geometry checks.
module tb_stmn_frame_aligner;

    localparam int L1 = 2430;
    localparam int L4 = 9720;
    localparam logic [7:0] A1 = 8'hF6;
    localparam logic [7:0] A2 = 8'h28;

    typedef struct {
        logic [7:0] din;
        int         exp_col;
    } hunt_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst4_n;
    logic [7:0]  din1, din4, dout1, dout4;
    logic        vld1, vld4, dv1, dv4;
    logic [3:0]  row1, row4;
    logic [8:0]  col1;
    logic [10:0] col4;
    logic        fs1, fs4, sync1, sync4, lof1, lof4;

    int checks   = 0;
    int failures = 0;

    stmn_frame_aligner #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(vld1),
        .dout(dout1), .dout_valid(dv1), .row(row1), .col(col1),
        .frame_start(fs1), .in_sync(sync1), .lof(lof1)
    );

    stmn_frame_aligner #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .din(din4), .din_valid(vld4),
        .dout(dout4), .dout_valid(dv4), .row(row4), .col(col4),
        .frame_start(fs4), .in_sync(sync4), .lof(lof4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic hunt_vec_t mk(input logic [7:0] d, input int c);
        hunt_vec_t v;
        v.din     = d;
        v.exp_col = c;
        return v;
    endfunction

    function automatic logic [7:0] noise_byte();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == A1 || b == A2);
        return b;
    endfunction

    function automatic logic [7:0] frame_byte(input int p, input int n, input bit corrupt);
        if (p < 3 * n) return A1;
        if (p < 6 * n) return (corrupt && p == 3 * n + 1) ? 8'h00 : A2;
        return noise_byte();
    endfunction

    // Expected pre-byte alignment and post-byte sync for the STM-1 main scenario (s counts
    // from the first A1 of frame 0; reset lands before s = 14*L1+101).
    function automatic bit n1_aligned(input int s);
        if (s <= 14 * L1 + 100) return (s >= 6 && s <= 10 * L1 + 5) || (s >= 11 * L1 + 6);
        return s >= 15 * L1 + 6;
    endfunction

    function automatic bit n1_sync(input int s);
        if (s <= 14 * L1 + 100) return (s >= 2 * L1 + 5 && s <= 10 * L1 + 4) || (s >= 13 * L1 + 5);
        return s >= 17 * L1 + 5;
    endfunction

    task automatic drive1(input logic [7:0] b);
        din1 = b;
        vld1 = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic [7:0] b, input int er, input int ec,
                          input bit efs, input bit esync, input bit elof);
        chk({tag, " dout"}, int'(dout1), int'(b));
        chk({tag, " dout_valid"}, int'(dv1), 1);
        chk({tag, " row"}, int'(row1), er);
        chk({tag, " col"}, int'(col1), ec);
        chk({tag, " frame_start"}, int'(fs1), int'(efs));
        chk({tag, " in_sync"}, int'(sync1), int'(esync));
        chk({tag, " lof"}, int'(lof1), int'(elof));
    endtask

    task automatic check_reset1(input string tag);
        chk({tag, " dout"}, int'(dout1), 0);
        chk({tag, " dout_valid"}, int'(dv1), 0);
        chk({tag, " row"}, int'(row1), 0);
        chk({tag, " col"}, int'(col1), 0);
        chk({tag, " frame_start"}, int'(fs1), 0);
        chk({tag, " in_sync"}, int'(sync1), 0);
        chk({tag, " lof"}, int'(lof1), 0);
    endtask

    task automatic run_n1();
        logic [7:0] b;
        hunt_vec_t  tbl[$];
        int         f, p;
        bit         cor, al, sy, lf;

        for (int i = 0; i < 5000; i++) begin
            b = noise_byte();
            drive1(b);
            check1($sformatf("noise%0d", i), b, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        // Short A1 run, an A1 breaking the A2 run, then a long A1 run that must acquire.
        tbl.push_back(mk(8'h00, 0));
        tbl.push_back(mk(A1, 0)); tbl.push_back(mk(A1, 0)); tbl.push_back(mk(A2, 0));
        tbl.push_back(mk(A1, 0)); tbl.push_back(mk(A1, 0)); tbl.push_back(mk(A1, 0));
        tbl.push_back(mk(A2, 0)); tbl.push_back(mk(A1, 0)); tbl.push_back(mk(A2, 0));
        tbl.push_back(mk(A2, 0));
        tbl.push_back(mk(8'h11, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(A1, 0));
        tbl.push_back(mk(A2, 0)); tbl.push_back(mk(A2, 0)); tbl.push_back(mk(A2, 0));
        tbl.push_back(mk(8'h33, 6)); tbl.push_back(mk(8'h44, 7)); tbl.push_back(mk(8'h55, 8));
        for (int i = 0; i < tbl.size(); i++) begin
            drive1(tbl[i].din);
            check1($sformatf("hunt%0d", i), tbl[i].din, 0, tbl[i].exp_col, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = -5; s < 17 * L1 + 20; s++) begin
            if (s == 14 * L1 + 101) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_reset1("midreset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            if (s < 0) begin
                b  = noise_byte();
                p  = 0;
                al = 1'b0;
                sy = 1'b0;
                lf = 1'b0;
            end else begin
                f   = s / L1;
                p   = s % L1;
                cor = (f inside {3, 4, 5, 7, 8, 9, 10});
                b   = frame_byte(p, 1, cor);
                al  = n1_aligned(s);
                sy  = n1_sync(s);
                lf  = (s == 10 * L1 + 5);
            end
            drive1(b);
            check1($sformatf("n1 s=%0d", s), b, al ? p / 270 : 0, al ? p % 270 : 0,
                   al && (p == 0), sy, lf);
        end
    endtask

    task automatic run_n4();
        logic [7:0] b, last;
        int         s, p, maxcol;
        bit         al;
        last   = 8'h00;
        maxcol = 0;
        s      = -10;
        while (s < 3 * L4 + 30) begin
            if ($urandom_range(0, 1) == 0) begin
                din4 = 8'($urandom_range(0, 255));
                vld4 = 1'b0;
                @(posedge clk);
                #1;
                chk("n4 idle dout_valid", int'(dv4), 0);
                chk("n4 idle dout hold", int'(dout4), int'(last));
                chk("n4 idle frame_start", int'(fs4), 0);
            end else begin
                b    = (s < 0) ? noise_byte() : frame_byte(s % L4, 4, 1'b0);
                din4 = b;
                vld4 = 1'b1;
                @(posedge clk);
                #1;
                p  = (s < 0) ? 0 : s % L4;
                al = (s >= 24);
                chk($sformatf("n4 s=%0d dout", s), int'(dout4), int'(b));
                chk($sformatf("n4 s=%0d dout_valid", s), int'(dv4), 1);
                chk($sformatf("n4 s=%0d row", s), int'(row4), al ? p / 1080 : 0);
                chk($sformatf("n4 s=%0d col", s), int'(col4), al ? p % 1080 : 0);
                chk($sformatf("n4 s=%0d frame_start", s), int'(fs4), int'(al && p == 0));
                chk($sformatf("n4 s=%0d in_sync", s), int'(sync4), int'(s >= 2 * L4 + 23));
                chk($sformatf("n4 s=%0d lof", s), int'(lof4), 0);
                if (int'(col4) > maxcol) maxcol = int'(col4);
                last = b;
                s++;
            end
        end
        chk("n4 col max", maxcol, 1079);
        chk("n4 in_sync end", int'(sync4), 1);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: got no finish, required finish within 200000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        din1   = 8'h00;
        din4   = 8'h00;
        vld1   = 1'b0;
        vld4   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset1("reset1");
        chk("reset4 dout", int'(dout4), 0);
        chk("reset4 dout_valid", int'(dv4), 0);
        chk("reset4 row", int'(row4), 0);
        chk("reset4 col", int'(col4), 0);
        chk("reset4 frame_start", int'(fs4), 0);
        chk("reset4 in_sync", int'(sync4), 0);
        chk("reset4 lof", int'(lof4), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        fork
            run_n1();
            run_n4();
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
